// File: rtl/pc_sequencer_if.sv
// Bus bundle for pc_sequencer: control/target inputs from the fetch stage
// and the PC / return-address-stack status outputs.
// Module header note: the RAS outputs are only live when the sequencer is
// built with PC_SEQUENCER_RAS_EN; otherwise they read as constants.
interface pc_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             stall;
  logic [1:0]       jump;
  logic [31:0]      instruction;
  logic [WIDTH-1:0] j_Reg;
  logic [WIDTH-1:0] branch_Destiny;
  logic             branch_Result;
  logic             link;
  logic             ret;

  logic [WIDTH-1:0] PC;
  logic [WIDTH-1:0] next_PC;
  logic [WIDTH-1:0] jump_Result;
  logic             ras_hit;
  logic             ras_empty;
  logic             ras_full;
  logic [15:0]      ras_miss_count;

  modport master (
    output stall, jump, instruction, j_Reg, branch_Destiny, branch_Result, link, ret,
    input  PC, next_PC, jump_Result, ras_hit, ras_empty, ras_full, ras_miss_count
  );

  modport slave (
    input  stall, jump, instruction, j_Reg, branch_Destiny, branch_Result, link, ret,
    output PC, next_PC, jump_Result, ras_hit, ras_empty, ras_full, ras_miss_count
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with an optional advisory return-address stack.
// Optional feature macro: PC_SEQUENCER_RAS_EN builds in the RAS storage,
// ras_hit and the saturating mispredicted-return counter. Without it the
// RAS outputs are tied off and link/ret are ignored; PC behaviour is the same.
module pc_sequencer #(
  parameter int               WIDTH     = 32,
  parameter int               RAS_DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_PC  = '0
) (
  input  logic          clk,
  input  logic          reset,
  pc_sequencer_if.slave bus
);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] next_pc;
  logic [WIDTH-1:0] abs_target;
  logic [WIDTH-1:0] jump_target;

  assign next_pc = pc_q + WIDTH'(4);

  // Absolute jump keeps the region bits of PC+4, zero fill above the word index.
  always_comb begin
    abs_target                = '0;
    abs_target[27:0]          = {bus.instruction[25:0], 2'b00};
    abs_target[WIDTH-1 -: 4]  = next_pc[WIDTH-1 -: 4];
  end

  // Next-PC selection from the jump code.
  always_comb begin
    jump_target = next_pc;
    case (bus.jump)
      2'b01:   jump_target = abs_target;
      2'b10:   jump_target = bus.j_Reg;
      2'b11:   jump_target = bus.branch_Result ? bus.branch_Destiny : next_pc;
      default: jump_target = next_pc;
    endcase
  end

  // PC register; reset wins over stall.
  always_ff @(posedge clk) begin
    if (reset)
      pc_q <= RESET_PC;
    else if (!bus.stall)
      pc_q <= jump_target;
  end

  assign bus.PC          = pc_q;
  assign bus.next_PC     = next_pc;
  assign bus.jump_Result = jump_target;

`ifdef PC_SEQUENCER_RAS_EN
  localparam int              PTR_W    = $clog2(RAS_DEPTH);
  localparam logic [PTR_W:0]  FULL_CNT = (PTR_W+1)'(RAS_DEPTH);

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] top_q;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   cnt_q;
  logic [15:0]      miss_q;
  logic             is_ret;
  logic             empty;
  logic             full;
  logic             hit;
  logic             push;
  logic             pop;
  logic             unused_bits;

  assign is_ret = (bus.jump == 2'b10) && bus.ret;
  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == FULL_CNT);
  assign hit    = is_ret && !empty && (ras_mem[top_q] == bus.j_Reg);
  assign pop    = !bus.stall && is_ret && !empty;
  assign push   = !bus.stall && bus.link;
  // A simultaneous pop and push overwrites the current top in place.
  assign wr_ptr = pop ? top_q : top_q + 1'b1;

  // Top pointer and occupancy; a push while full wraps onto the oldest slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      top_q <= '0;
      cnt_q <= '0;
    end else if (push && !pop) begin
      top_q <= top_q + 1'b1;
      if (!full)
        cnt_q <= cnt_q + 1'b1;
    end else if (pop && !push) begin
      top_q <= top_q - 1'b1;
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Entry storage; contents are stale after reset but unreachable until pushed.
  always_ff @(posedge clk) begin
    if (push)
      ras_mem[wr_ptr] <= next_pc;
  end

  // Saturating count of returns the stack failed to predict.
  always_ff @(posedge clk) begin
    if (reset)
      miss_q <= '0;
    else if (!bus.stall && is_ret && !hit && (miss_q != 16'hFFFF))
      miss_q <= miss_q + 16'd1;
  end

  assign bus.ras_hit        = hit;
  assign bus.ras_empty      = empty;
  assign bus.ras_full       = full;
  assign bus.ras_miss_count = miss_q;
  assign unused_bits        = ^bus.instruction[31:26];
`else
  logic unused_bits;

  assign bus.ras_hit        = 1'b0;
  assign bus.ras_empty      = 1'b1;
  assign bus.ras_full       = 1'b0;
  assign bus.ras_miss_count = 16'd0;
  assign unused_bits        = ^{bus.instruction[31:26], bus.link, bus.ret};
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer (WIDTH=32, RAS_DEPTH=4,
// RESET_PC=0x00400000). Works with or without PC_SEQUENCER_RAS_EN.
module tb_pc_sequencer;
  localparam logic [31:0] RST_PC = 32'h0040_0000;
`ifdef PC_SEQUENCER_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  pc_sequencer_if #(.WIDTH(32)) bus ();

  pc_sequencer #(.WIDTH(32), .RAS_DEPTH(4), .RESET_PC(RST_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: PC value, RAS as a queue (back = top), miss counter.
  logic [31:0] m_pc;
  logic [31:0] m_ras[$];
  int          m_miss;
  bit          m_valid = 1'b0;
  bit          u_hit;
  logic [31:0] u_next;
  logic [31:0] u_tgt;

  function automatic logic [31:0] m_target();
    logic [31:0] n;
    n = m_pc + 32'd4;
    case (bus.jump)
      2'b00:   return n;
      2'b01:   return {n[31:28], bus.instruction[25:0], 2'b00};
      2'b10:   return bus.j_Reg;
      default: return bus.branch_Result ? bus.branch_Destiny : n;
    endcase
  endfunction

  function automatic bit m_hit();
    if (!RAS_ON) return 1'b0;
    return (bus.jump == 2'b10) && bus.ret && (m_ras.size() > 0) && (m_ras[$] == bus.j_Reg);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_pc    = RST_PC;
      m_ras.delete();
      m_miss  = 0;
      m_valid = 1'b1;
    end else if (m_valid && !bus.stall) begin
      u_hit  = m_hit();
      u_next = m_pc + 32'd4;
      u_tgt  = m_target();
      if (RAS_ON) begin
        if (bus.jump == 2'b10 && bus.ret) begin
          if (!u_hit && m_miss < 65535) m_miss++;
          if (m_ras.size() > 0) void'(m_ras.pop_back());
        end
        if (bus.link) begin
          m_ras.push_back(u_next);
          if (m_ras.size() > 4) void'(m_ras.pop_front());
        end
      end
      m_pc = u_tgt;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("pc",          bus.PC,          m_pc);
      chk("next_pc",     bus.next_PC,     m_pc + 32'd4);
      chk("jump_result", bus.jump_Result, m_target());
      chk("ras_hit",     {31'd0, bus.ras_hit},   {31'd0, m_hit()});
      chk("ras_empty",   {31'd0, bus.ras_empty}, {31'd0, (RAS_ON ? (m_ras.size() == 0) : 1'b1)});
      chk("ras_full",    {31'd0, bus.ras_full},  {31'd0, (RAS_ON ? (m_ras.size() == 4) : 1'b0)});
      chk("ras_miss",    {16'd0, bus.ras_miss_count}, 32'(m_miss));
    end
  end

  task automatic apply(input bit st, input logic [1:0] j, input logic [31:0] ins,
                       input logic [31:0] jr, input logic [31:0] bd, input bit br,
                       input bit lk, input bit rt);
    bus.stall          = st;
    bus.jump           = j;
    bus.instruction    = ins;
    bus.j_Reg          = jr;
    bus.branch_Destiny = bd;
    bus.branch_Result  = br;
    bus.link           = lk;
    bus.ret            = rt;
    @(negedge clk);
    #1;
  endtask

  task automatic adv();
    @(posedge clk);
    #2;
  endtask

  task automatic go(input bit st, input logic [1:0] j, input logic [31:0] ins,
                    input logic [31:0] jr, input logic [31:0] bd, input bit br,
                    input bit lk, input bit rt);
    apply(st, j, ins, jr, bd, br, lk, rt);
    adv();
  endtask

  logic [31:0] tops [4];

  initial begin
    reset = 1'b1;
    apply(0, 2'b00, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    adv();
    adv();
    chk("rst_pc",    bus.PC,      32'h0040_0000);
    chk("rst_next",  bus.next_PC, 32'h0040_0004);
    chk("rst_empty", {31'd0, bus.ras_empty}, 32'd1);
    chk("rst_full",  {31'd0, bus.ras_full},  32'd0);
    chk("rst_miss",  {16'd0, bus.ras_miss_count}, 32'd0);
    chk("rst_hit",   {31'd0, bus.ras_hit}, 32'd0);
    reset = 1'b0;

    go(0, 2'b00, 0, 0, 0, 0, 0, 0); chk("seq1", bus.PC, 32'h0040_0004);
    go(0, 2'b00, 0, 0, 0, 0, 0, 0); chk("seq2", bus.PC, 32'h0040_0008);
    go(0, 2'b00, 0, 0, 0, 0, 0, 0); chk("seq3", bus.PC, 32'h0040_000C);

    go(0, 2'b10, 0, 32'h1000_0000, 0, 0, 0, 0); chk("jreg", bus.PC, 32'h1000_0000);
    apply(1, 2'b01, 32'h0000_0010, 0, 0, 0, 0, 0);
    chk("abs_target", bus.jump_Result, 32'h1000_0040);
    adv(); chk("abs_stall", bus.PC, 32'h1000_0000);
    go(0, 2'b01, 32'hFC00_0010, 0, 0, 0, 0, 0); chk("abs_jump", bus.PC, 32'h1000_0040);

    go(0, 2'b11, 0, 0, 32'h0000_0100, 1, 0, 0); chk("br_taken", bus.PC, 32'h0000_0100);
    go(0, 2'b11, 0, 0, 32'h0000_0800, 0, 0, 0); chk("br_not",   bus.PC, 32'h0000_0104);

    // Call / return pair and a return with an empty stack.
    go(0, 2'b10, 0, 32'h20, 0, 0, 0, 0);
    go(0, 2'b00, 0, 0, 0, 0, 1, 0); chk("call_pc", bus.PC, 32'h24);
    apply(0, 2'b10, 0, 32'h24, 0, 0, 0, 1);
    chk("ret_hit", {31'd0, bus.ras_hit}, {31'd0, RAS_ON});
    adv();
    chk("ret_pc",    bus.PC, 32'h24);
    chk("ret_empty", {31'd0, bus.ras_empty}, 32'd1);
    chk("ret_miss0", {16'd0, bus.ras_miss_count}, 32'd0);
    apply(0, 2'b10, 0, 32'h24, 0, 0, 0, 1);
    chk("ret2_hit", {31'd0, bus.ras_hit}, 32'd0);
    adv();
    chk("ret2_miss", {16'd0, bus.ras_miss_count}, {31'd0, RAS_ON});

    // Five calls into a four-deep stack; the oldest return address is lost.
    go(0, 2'b10, 0, 32'h1000, 0, 0, 1, 0);
    go(0, 2'b10, 0, 32'h2000, 0, 0, 1, 0);
    go(0, 2'b10, 0, 32'h3000, 0, 0, 1, 0);
    go(0, 2'b10, 0, 32'h4000, 0, 0, 1, 0);
    go(0, 2'b10, 0, 32'h5000, 0, 0, 1, 0);
    chk("full5", {31'd0, bus.ras_full}, {31'd0, RAS_ON});
    chk("pc5",   bus.PC, 32'h5000);
    tops[0] = 32'h4004; tops[1] = 32'h3004; tops[2] = 32'h2004; tops[3] = 32'h1004;
    for (int i = 0; i < 4; i++) begin
      apply(0, 2'b10, 0, tops[i], 0, 0, 0, 1);
      chk("pop_hit", {31'd0, bus.ras_hit}, {31'd0, RAS_ON});
      adv();
      chk("pop_pc", bus.PC, tops[i]);
    end
    chk("pop_empty", {31'd0, bus.ras_empty}, 32'd1);
    apply(0, 2'b10, 0, 32'h0024, 0, 0, 0, 1);
    chk("lost_a1", {31'd0, bus.ras_hit}, 32'd0);
    adv();

    // Stalled link/ret must not disturb the stack or the counter.
    go(1, 2'b00, 0, 0, 0, 0, 1, 0);
    go(1, 2'b10, 0, 32'h0, 0, 0, 1, 1);
    chk("stall_empty", {31'd0, bus.ras_empty}, 32'd1);

    // Push then simultaneous pop+push replaces the top.
    go(0, 2'b10, 0, 32'h0000_0200, 0, 0, 1, 0);
    go(0, 2'b10, 0, 32'h0000_0300, 0, 0, 0, 0);
    go(0, 2'b10, 0, 32'h0000_0028, 0, 0, 1, 1);
    apply(0, 2'b10, 0, 32'h0000_0304, 0, 0, 0, 1);
    chk("swap_hit", {31'd0, bus.ras_hit}, {31'd0, RAS_ON});
    adv();
    chk("swap_empty", {31'd0, bus.ras_empty}, 32'd1);

    // Reset mid-sequence with stall high discards the stack.
    go(0, 2'b00, 0, 0, 0, 0, 1, 0);
    go(0, 2'b00, 0, 0, 0, 0, 1, 0);
    reset = 1'b1;
    go(1, 2'b00, 0, 0, 0, 0, 1, 0);
    reset = 1'b0;
    chk("mid_rst_pc",    bus.PC, RST_PC);
    chk("mid_rst_empty", {31'd0, bus.ras_empty}, 32'd1);
    chk("mid_rst_miss",  {16'd0, bus.ras_miss_count}, 32'd0);
    go(0, 2'b00, 0, 0, 0, 0, 0, 0);
    chk("post_rst_pc", bus.PC, 32'h0040_0004);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter WIDTH, default 32, PC/address width in bits; legal values >= 32.
REQ-002 Parameter RAS_DEPTH, default 4, return-address-stack entries; power of two, >= 2.
REQ-003 Parameter RESET_PC, default 0, PC value loaded on reset.
REQ-004 clk  input  1  single rising-edge clock.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 stall  input  1  when 1, freezes all state (PC, RAS, counter).
REQ-007 jump  input  2  target select: 00 sequential, 01 absolute jump, 10 register jump, 11 conditional branch.
REQ-008 instruction  input  32  current instruction word; bits [25:0] are the jump index.
REQ-009 j_Reg  input  WIDTH  register-jump target.
REQ-010 branch_Destiny  input  WIDTH  branch target.
REQ-011 branch_Result  input  1  branch condition; 1 means taken.
REQ-012 link  input  1  current instruction writes a return address (jal/jalr); push request.
REQ-013 ret  input  1  current register jump is a subroutine return; pop request.
REQ-014 PC  output  WIDTH  registered program counter.
REQ-015 next_PC  output  WIDTH  PC + 4.
REQ-016 jump_Result  output  WIDTH  combinational next-PC selection.
REQ-017 ras_hit  output  1  RAS top matches j_Reg on a return.
REQ-018 ras_empty / ras_full  output  1 each  RAS occupancy flags.
REQ-019 ras_miss_count  output  16  saturating count of mispredicted returns.

Function
REQ-020 next_PC SHALL equal PC + 4 modulo 2^WIDTH, combinational.
REQ-021 jump_Result SHALL be: 00 -> next_PC; 01 -> {next_PC[WIDTH-1:WIDTH-4], zeros, instruction[25:0], 2'b00}, zero fill between; 10 -> j_Reg; 11 -> branch_Destiny if branch_Result=1, else next_PC.
REQ-022 On each rising clk with reset=0: stall=0 -> PC <= jump_Result; stall=1 -> PC holds.
REQ-023 The RAS SHALL be a circular LIFO of RAS_DEPTH WIDTH-bit entries with occupancy 0..RAS_DEPTH.
REQ-024 Push: stall=0 and link=1 -> next_PC written as new top; occupancy +1, saturating at RAS_DEPTH.
REQ-025 Push when full SHALL overwrite the oldest entry; ras_full stays 1; no error.
REQ-026 Pop: stall=0, jump=10, ret=1, ras_empty=0 -> top removed, occupancy -1.
REQ-027 Return with RAS empty SHALL leave the RAS unchanged.
REQ-028 Simultaneous pop and push in one cycle SHALL replace the top with next_PC; occupancy unchanged.
REQ-029 ras_hit SHALL be combinational: 1 iff jump=10, ret=1, ras_empty=0 and top == j_Reg.
REQ-030 ras_miss_count SHALL increment on each cycle with stall=0, jump=10, ret=1, ras_hit=0 (empty included); saturates at 16'hFFFF.
REQ-031 PC SHALL always follow j_Reg on register jumps regardless of ras_hit; the RAS is advisory only.
REQ-032 link=1 or ret=1 with stall=1 SHALL have no effect.

Reset
REQ-033 Reset is synchronous and active-high on clk; it overrides stall.
REQ-034 After reset: PC=RESET_PC, next_PC=RESET_PC+4, ras_empty=1, ras_full=0, ras_miss_count=0, ras_hit=0.
REQ-035 Reset asserted mid-sequence SHALL discard all RAS contents; entry data need not be cleared.

Configuration
REQ-036 Macro PC_SEQUENCER_RAS_EN compiles in the RAS, ras_hit and ras_miss_count logic.
REQ-037 Without PC_SEQUENCER_RAS_EN: no RAS storage; ras_hit=0, ras_empty=1, ras_full=0, ras_miss_count=0 constantly; link and ret are ignored; PC, next_PC and jump_Result behaviour are identical.

Verification
REQ-038 Reset with RESET_PC=32'h00400000, then 3 cycles jump=00 -> PC 00400004, 00400008, 0040000C.
REQ-039 PC=32'h10000000, jump=01, instruction[25:0]=26'h0000010 -> jump_Result=32'h10000040; PC updates next edge. Same with stall=1 -> PC holds.
REQ-040 jump=11: branch_Result=1, branch_Destiny=32'h00000100 -> PC=00000100; branch_Result=0 -> PC=previous+4.
REQ-041 PC=32'h20: link=1 (push 0x24), later jump=10, ret=1, j_Reg=32'h24 -> ras_hit=1, RAS empty after, ras_miss_count=0; repeat return with RAS empty -> ras_miss_count=1.
REQ-042 RAS_DEPTH=4: push 5 distinct addresses A1..A5 -> ras_full=1; pops return A5, A4, A3, A2, then ras_empty=1 (A1 lost).
REQ-043 Build without PC_SEQUENCER_RAS_EN: REQ-041 stimulus -> ras_hit=0, ras_miss_count=0, PC sequence unchanged.
